// File: rtl/mvp_pkg.sv
// Shared constants for the MVP weight-sweep sequencer: FSM encoding and parameter defaults.
// Declarations only, so there is no logic and no latency here.
// There is no handshake; the files that need these constants import them.
package mvp_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/mvp_vld_pipe.sv
// Valid delay line that mirrors the weight BRAM read latency.
// Latency is DEPTH cycles from in_vld to out_vld; a flush clears every stage on the next edge.
// There is no backpressure: the line shifts on every cycle.
module mvp_vld_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld,
    output logic drain_last
);

    logic [DEPTH-1:0] stg_q;
    logic [DEPTH-1:0] stg_d;

    always_comb begin
        stg_d = (stg_q << 1) | DEPTH'(in_vld);
        if (flush) begin
            stg_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign out_vld    = stg_q[DEPTH-1];
    // drain_last is high when only the output stage can still be occupied and nothing new enters.
    assign drain_last = !in_vld && ((stg_q << 1) == '0);

endmodule

// File: rtl/mvp_seq_ctrl.sv
// Weight-sweep sequencer: issues BRAM reads, aligns accumulate enables and captures the column sum.
// done is asserted length + RD_LAT + 2 cycles after start is accepted (2 cycles when length is 0).
// There is no backpressure: abort cancels the sweep, and start is ignored unless the FSM is idle.
module mvp_seq_ctrl
    import mvp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_clr,
    output logic              acc_en,
    input  logic [DATA_W-1:0] sum_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    // A latency outside the supported BRAM range is clamped to the nearest supported value.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              accept;
    logic              pipe_flush;
    logic              drain_last;

    assign accept = (state_q == ST_IDLE) && start && !abort;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        pipe_flush = 1'b0;
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            pipe_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_d = length;
                        // With a zero length the address register is left alone, so rd_addr keeps its last value.
                        if (length == '0) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            addr_d  = base_addr;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_d = cnt_q - ADDR_W'(1);
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    result_d = sum_in;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    mvp_vld_pipe #(
        .DEPTH (LAT)
    ) u_vld_pipe (
        .clk        (clk),
        .rst        (rst),
        .flush      (pipe_flush),
        .in_vld     (rd_en),
        .out_vld    (acc_en),
        .drain_last (drain_last)
    );

    assign rd_en   = (state_q == ST_ISSUE);
    assign rd_addr = addr_q;
    // The clear is qualified with reset so it stays low while reset is asserted, whatever start does.
    assign acc_clr = accept && rst;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;

endmodule

// File: tb/tb_mvp_seq_ctrl.sv
// Scoreboard bench for mvp_seq_ctrl, with a modelled weight BRAM and accumulator around the DUT.
// The expected event stream is produced when stimulus is issued, and is checked one cycle at a time.
// There is no backpressure: the DUT is free-running and the bench only samples it.
module tb_mvp_seq_ctrl;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              rd_en, acc_clr, acc_en, busy, done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] sum_in, result;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sweep_t0 = -1;
    int busy_end = -1;
    int e_mon;
    logic              exp_b;
    logic [ADDR_W-1:0] exp_last_addr = '0;
    logic [DATA_W-1:0] exp_result = '0;
    ev_t q_rd[$], q_acc[$], q_clr[$], q_done[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mvp_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .sum_in    (sum_in),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    function automatic logic [31:0] wgt(input logic [ADDR_W-1:0] a);
        return {14'h0, a} * 32'h9E3779B1 + 32'd7;
    endfunction

    // Environment: weight BRAM with RD_LAT read latency, plus the column accumulator.
    logic [DATA_W-1:0] rdat_q [RD_LAT];
    logic [DATA_W-1:0] acc_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) rdat_q[i] <= '0;
        end else begin
            rdat_q[0] <= rd_en ? wgt(rd_addr) : '0;
            for (int i = 1; i < RD_LAT; i++) rdat_q[i] <= rdat_q[i-1];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else if (acc_clr) acc_q <= '0;
        else if (acc_en) acc_q <= acc_q + rdat_q[RD_LAT-1];
    end

    assign sum_in = acc_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", nm, cyc + 1, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"},   32'(rd_en),   32'd0);
        chk({tag, "_acc_en"},  32'(acc_en),  32'd0);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_result"},  32'(result),  32'd0);
    endtask

    // Reference model: a request that reaches edge t0 expands into the complete list of events it should cause.
    task automatic drive(input logic s, input logic a,
                         input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
        int                t0;
        logic [DATA_W-1:0] sum;
        logic [ADDR_W-1:0] ai;
        t0 = cyc + 1;
        start = s;
        abort = a;
        base_addr = b;
        length = l;
        if (t0 <= busy_end) begin
            if (a) begin
                while (q_rd.size() > 0 && q_rd[$].cyc > t0) void'(q_rd.pop_back());
                while (q_acc.size() > 0 && q_acc[$].cyc > t0) void'(q_acc.pop_back());
                while (q_done.size() > 0 && q_done[$].cyc > t0) void'(q_done.pop_back());
                busy_end = t0;
            end
        end else if (s && !a) begin
            sum = '0;
            q_clr.push_back('{t0, 32'd0});
            for (int i = 0; i < int'(l); i++) begin
                ai = b + ADDR_W'(i);
                q_rd.push_back('{t0 + 1 + i, 32'(ai)});
                q_acc.push_back('{t0 + 1 + RD_LAT + i, 32'd0});
                sum += wgt(ai);
            end
            sweep_t0 = t0;
            busy_end = (l == '0) ? t0 + 2 : t0 + int'(l) + RD_LAT + 2;
            q_done.push_back('{busy_end, sum});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            drive(1'b0, 1'b0, '0, '0);
        end
    endtask

    // Monitor: the outputs seen at the falling edge are the values that the next rising edge samples.
    always @(negedge clk) begin
        if (rst) begin
            e_mon = cyc + 1;

            exp_b = (q_rd.size() > 0 && q_rd[0].cyc == e_mon);
            chk("rd_en", 32'(rd_en), 32'(exp_b));
            if (exp_b) begin
                if (rd_en) chk("rd_addr", 32'(rd_addr), q_rd[0].val);
                exp_last_addr = q_rd[0].val[ADDR_W-1:0];
                void'(q_rd.pop_front());
            end else if (!rd_en) begin
                chk("rd_addr_hold", 32'(rd_addr), 32'(exp_last_addr));
            end

            exp_b = (q_acc.size() > 0 && q_acc[0].cyc == e_mon);
            chk("acc_en", 32'(acc_en), 32'(exp_b));
            if (exp_b) void'(q_acc.pop_front());

            exp_b = (q_clr.size() > 0 && q_clr[0].cyc == e_mon);
            chk("acc_clr", 32'(acc_clr), 32'(exp_b));
            if (exp_b) void'(q_clr.pop_front());

            exp_b = (q_done.size() > 0 && q_done[0].cyc == e_mon);
            chk("done", 32'(done), 32'(exp_b));
            if (exp_b) begin
                exp_result = q_done[0].val;
                void'(q_done.pop_front());
            end
            chk("result", result, exp_result);

            chk("busy", 32'(busy), 32'(e_mon > sweep_t0 && e_mon <= busy_end));
        end
    end

    logic [ADDR_W-1:0] rb, rl;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        // The first start is presented right after reset is released: the basic sweep.
        @(posedge clk);
        #3;
        rst = 1'b1;
        drive(1'b1, 1'b0, 18'h00010, 18'd4);
        idle(12);

        // A sweep that wraps the address space.
        step(); drive(1'b1, 1'b0, 18'h3FFFE, 18'd4); idle(10);
        // A zero-length sweep.
        step(); drive(1'b1, 1'b0, 18'h00123, 18'd0); idle(4);
        // An abort two cycles into a length-8 sweep.
        step(); drive(1'b1, 1'b0, 18'h00200, 18'd8);
        step(); drive(1'b0, 1'b0, '0, '0);
        step(); drive(1'b0, 1'b1, '0, '0);
        idle(6);
        // start and abort together while idle: abort takes priority.
        step(); drive(1'b1, 1'b1, 18'h00300, 18'd3); idle(3);
        // A start during ISSUE, a start in the DONE cycle, then a start on the cycle after DONE.
        step(); drive(1'b1, 1'b0, 18'h00400, 18'd4);
        step(); drive(1'b0, 1'b0, '0, '0);
        step(); drive(1'b1, 1'b0, 18'h00500, 18'd2);
        idle(5);
        step(); drive(1'b1, 1'b0, 18'h00600, 18'd3);
        step(); drive(1'b1, 1'b0, 18'h00700, 18'd2);
        idle(10);

        // Reset asserted during DRAIN, then the basic sweep run again.
        step(); drive(1'b1, 1'b0, 18'h00040, 18'd4);
        idle(5);
        #2;
        rst = 1'b0;
        start = 1'b1;
        #1;
        check_zero("mid_reset");
        start = 1'b0;
        q_rd.delete(); q_acc.delete(); q_clr.delete(); q_done.delete();
        sweep_t0 = -1;
        busy_end = -1;
        exp_last_addr = '0;
        exp_result = '0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        drive(1'b1, 1'b0, 18'h00010, 18'd4);
        idle(12);

        // Random traffic: starts, occasional aborts, near-top base addresses and zero lengths.
        repeat (400) begin
            step();
            rb = ($urandom_range(0, 3) == 0) ? 18'h3FFFF - 18'($urandom_range(0, 5))
                                             : 18'($urandom);
            rl = ($urandom_range(0, 7) == 0) ? 18'd0 : 18'($urandom_range(1, 12));
            drive(1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 3), rb, rl);
        end
        idle(30);

        chk("queues_drained", 32'(q_rd.size() + q_acc.size() + q_clr.size() + q_done.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mvp_seq_ctrl.md
MVP_SEQ_CTRL -- requirements
Module: mvp_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 18, weight-memory address width.
- DATA_W, 32, accumulator result width.
- RD_LAT, 2, read latency of the weight BRAM port B, in cycles (1..4).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on its rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to run a weight sweep.
- abort, input, 1, cancel the sweep in progress.
- base_addr, input, ADDR_W, first weight address.
- length, input, ADDR_W, number of weight words to fetch.
- rd_en, output, 1, read strobe to all four weight BRAM B ports.
- rd_addr, output, ADDR_W, shared address to the four weight BRAM B ports.
- acc_clr, output, 1, synchronous clear to the column accumulator.
- acc_en, output, 1, marks the current weight word as valid for accumulation.
- sum_in, input, DATA_W, accumulator output (column_0_out).
- busy, output, 1, high whenever the FSM is not IDLE.
- done, output, 1, one-cycle completion pulse.
- result, output, DATA_W, final accumulated sum, held until the next start.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, DRAIN, CAPTURE and DONE.
REQ-004 In IDLE, start=1 SHALL latch base_addr and length, pulse acc_clr for that cycle, and move the FSM to ISSUE; or to CAPTURE if length=0.
REQ-005 start outside IDLE SHALL be ignored, with no effect on the latched parameters.
REQ-006 In ISSUE, rd_en SHALL be 1 for exactly `length` consecutive cycles, with rd_addr = base_addr + i for i = 0..length-1.
REQ-007 Address arithmetic SHALL be modulo 2^ADDR_W: wrap past all-ones to 0 with no error.
REQ-008 acc_en SHALL be rd_en delayed by exactly RD_LAT cycles through a shift register.
REQ-009 After the last issue, the FSM SHALL stay in DRAIN until the delay pipeline is empty.
REQ-010 The FSM SHALL then spend one cycle in CAPTURE, during which the accumulator registers its last word.
REQ-011 On the CAPTURE-to-DONE edge, result SHALL be loaded from sum_in.
REQ-012 done SHALL be high only during the single DONE cycle, after which the FSM returns to IDLE.
REQ-013 Timing: start sampled at edge t0 -> rd_en at t0+1..t0+L -> acc_en at t0+1+RD_LAT..t0+L+RD_LAT -> done at t0+L+RD_LAT+2.
REQ-014 For length=0: no rd_en, no acc_en, result = sum_in as seen after the clear (0), and done at t0+2.
REQ-015 abort=1 in any non-IDLE state SHALL, on the next edge:
- force IDLE;
- zero rd_en, acc_en and the delay pipeline;
- suppress done;
- leave result unchanged.
REQ-016 If abort and start are both high in IDLE, abort SHALL win and the start SHALL be dropped.
REQ-017 rd_addr SHALL hold its last value whenever rd_en=0.
REQ-018 busy SHALL be high from the cycle after an accepted start through the DONE cycle inclusive.

Reset
REQ-019 While rst=0, asynchronously:
- FSM = IDLE;
- rd_en, acc_en, acc_clr, done and busy = 0;
- rd_addr = 0, result = 0;
- delay pipeline and all counters cleared.
REQ-020 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-021 The first start is accepted on the first edge after rst deasserts.

Structure
REQ-022 The FSM state encoding, the ADDR_W/DATA_W defaults and the RD_LAT bound SHALL live in shared package mvp_pkg.
REQ-023 The RD_LAT-deep valid delay line SHALL be a separate sub-module, mvp_vld_pipe, parameterised by depth.
REQ-024 The block SHALL be single-clock, with no combinational path from sum_in to any output.

Verification
REQ-025 Base sweep, RD_LAT=2: base=0x00010, length=4, start at t0.
- rd_addr = 0x10..0x13 at t0+1..t0+4.
- acc_en at t0+3..t0+6.
- done at t0+8; result = sum_in sampled at t0+7.
REQ-026 Wrap-around: base=0x3FFFE, length=4 -> rd_addr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-027 Zero length: length=0 -> no rd_en, no acc_en, acc_clr at t0, done at t0+2, result=0.
REQ-028 Abort mid-sweep: abort at t0+2 of a length-8 sweep -> IDLE at t0+3, acc_en stays 0 afterwards, no done, result keeps its previous value.
REQ-029 Start while busy: a second start during ISSUE is ignored; a start in the same cycle as DONE is ignored; a start the cycle after DONE is accepted.
REQ-030 Reset mid-sweep: rst=0 during DRAIN -> all outputs 0 immediately (asynchronous), and a new sweep after release behaves exactly as in REQ-025.
